// File: rtl/eth_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging N_SRC AXI-stream sources onto one MAC tx_axis port.
// Optional frame/abort statistics counters are built when ARB_STATS_EN is defined.
module eth_tx_pkt_arbiter #(
  parameter int N_SRC         = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int STALL_TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_SRC*DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [N_SRC*KEEP_WIDTH-1:0]      s_axis_tkeep,
  input  logic [N_SRC-1:0]                 s_axis_tvalid,
  output logic [N_SRC-1:0]                 s_axis_tready,
  input  logic [N_SRC-1:0]                 s_axis_tlast,
  input  logic [N_SRC-1:0]                 s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tuser,
  input  logic                             m_axis_tready,
  output logic [$clog2(N_SRC)-1:0]         grant_idx,
  output logic                             busy,
  output logic                             stall_abort,
  output logic [31:0]                      pkt_count,
  output logic [15:0]                      abort_count
);

  localparam int IDX_W = $clog2(N_SRC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_ABORT = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [7:0]              stall_cnt_q, stall_cnt_d;
  logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic [KEEP_WIDTH-1:0]   m_tkeep_q, m_tkeep_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic                    m_tlast_q, m_tlast_d;
  logic                    m_tuser_q, m_tuser_d;
  logic                    abort_pulse_q, abort_start;

  logic [DATA_WIDTH-1:0]   g_tdata;
  logic [KEEP_WIDTH-1:0]   g_tkeep;
  logic                    g_tvalid, g_tlast, g_tuser;
  logic                    slot_free, src_rdy, g_hs;
  logic [IDX_W-1:0]        rr_sel;

  // First requester after ptr, wrapping modulo N_SRC (ptr itself is checked last).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] ptr,
                                               input logic [N_SRC-1:0] req);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = (int'(ptr) + k) % N_SRC;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
    return pick;
  endfunction

  assign rr_sel    = rr_pick(rr_ptr_q, s_axis_tvalid);
  assign g_tdata   = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign g_tkeep   = s_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
  assign g_tvalid  = s_axis_tvalid[grant_q];
  assign g_tlast   = s_axis_tlast[grant_q];
  assign g_tuser   = s_axis_tuser[grant_q];
  assign slot_free = !m_tvalid_q || m_axis_tready;
  // DRAIN sinks source beats without touching the slot, so it ignores MAC backpressure.
  assign src_rdy   = ((state_q == ST_PASS) && slot_free) || (state_q == ST_DRAIN);
  assign g_hs      = g_tvalid && src_rdy;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ready
    assign s_axis_tready[gi] = src_rdy && (grant_q == IDX_W'(gi));
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    stall_cnt_d = stall_cnt_q;
    m_tdata_d   = m_tdata_q;
    m_tkeep_d   = m_tkeep_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    m_tuser_d   = m_tuser_q;
    abort_start = 1'b0;

    if (m_tvalid_q && m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        stall_cnt_d = '0;
        if (|s_axis_tvalid) begin
          grant_d = rr_sel;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        if (g_hs) begin
          m_tdata_d   = g_tdata;
          m_tkeep_d   = g_tkeep;
          m_tvalid_d  = 1'b1;
          m_tlast_d   = g_tlast;
          m_tuser_d   = g_tuser;
          stall_cnt_d = '0;
          if (g_tlast) begin
            rr_ptr_d = grant_q;
            state_d  = ST_IDLE;
          end
        end else if (!g_tvalid && slot_free) begin
          // A full slot held by MAC backpressure is not counted as a source stall.
          if (stall_cnt_q == 8'(STALL_TIMEOUT - 1)) begin
            stall_cnt_d = '0;
            abort_start = 1'b1;
            state_d     = ST_ABORT;
          end else begin
            stall_cnt_d = stall_cnt_q + 8'd1;
          end
        end
      end
      ST_ABORT: begin
        if (slot_free) begin
          m_tdata_d  = '0;
          m_tkeep_d  = KEEP_WIDTH'(1);
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b1;
          m_tuser_d  = 1'b1;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (g_hs && g_tlast) begin
          rr_ptr_d = grant_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= IDX_W'(N_SRC - 1);
      grant_q       <= '0;
      stall_cnt_q   <= '0;
      m_tdata_q     <= '0;
      m_tkeep_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tuser_q     <= 1'b0;
      abort_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      stall_cnt_q   <= stall_cnt_d;
      m_tdata_q     <= m_tdata_d;
      m_tkeep_q     <= m_tkeep_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      m_tuser_q     <= m_tuser_d;
      abort_pulse_q <= abort_start;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign grant_idx     = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign stall_abort   = abort_pulse_q;

`ifdef ARB_STATS_EN
  logic [31:0] pkt_count_q;
  logic [15:0] abort_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q   <= '0;
      abort_count_q <= '0;
    end else begin
      if (m_tvalid_q && m_axis_tready && m_tlast_q) begin
        pkt_count_q <= pkt_count_q + 32'd1;
      end
      if (abort_start && (abort_count_q != 16'hFFFF)) begin
        abort_count_q <= abort_count_q + 16'd1;
      end
    end
  end

  assign pkt_count   = pkt_count_q;
  assign abort_count = abort_count_q;
`else
  assign pkt_count   = '0;
  assign abort_count = '0;
`endif

endmodule
